uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

UART transmit frame controller: accepts a parallel byte through a start/busy handshake and serialises it onto `tx` as start bit, data LSB-first, optional parity bit and stop bit(s). It sequences the transmitter's parity generator through a load/result port pair and owns the bit-period timing. It sits between the host-side TX interface and the serial pin, alongside the parity generator in the UART transmitter.

## Interface
- `WIDTH`, 8 — data bits per frame.
- `CLKS_PER_BIT`, 16 — clock cycles per serial bit period; must be ≥ 2.
- `PARITY_EN`, 1 — 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, 0 — 0 means even parity (bit = XOR of data); 1 means odd parity (inverted XOR).
- `STOP_BITS`, 1 — number of stop bits, 1 or 2.

Ports:
- `clk` in 1 — single clock; all logic samples on the rising edge.
- `rst` in 1 — reset, synchronous and active-low.
- `tx_start` in 1 — request to send `tx_data`.
- `tx_data` in WIDTH — byte to send; sampled only on acceptance.
- `tx_busy` out 1 — frame in progress; requests are ignored while high.
- `tx_done` out 1 — one-cycle pulse on the final cycle of the last stop bit.
- `tx` out 1 — serial line; idles high.
- `par_load` out 1 — one-cycle load strobe to the parity generator.
- `par_data` out WIDTH — captured byte presented to the parity generator.
- `par_bit` in 1 — even-parity result from the generator; must be valid 1 cycle after `par_load`.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `tx`=1, `tx_busy`=0.
  - A `tx_start`=1 sample captures `tx_data` into the shift register and `par_data`, pulses `par_load`, and moves to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0; shift right at each bit-period end.
  - Bit counter runs 0..WIDTH-1.
  - After the last data bit, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY:
  - `tx` = `par_bit` XOR PARITY_ODD, registered on entry and held for the whole period.
  - Then go to STOP.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Loads CLKS_PER_BIT-1 on every state entry and counts down.
  - A bit period ends when the counter reaches 0.
  - Width is clog2(CLKS_PER_BIT).
- `tx_start` while busy: ignored; `tx_data` is not captured and there is no queueing.
- `tx_start` held high continuously: a new frame is accepted on the first IDLE cycle after each frame.
- Reset (`rst`=0 at a clock edge), including mid-frame:
  - Next state is IDLE.
  - `tx`=1, `tx_busy`=0, `tx_done`=0, `par_load`=0, `par_data`=0.
  - Shift register, bit counter and baud counter are cleared.
- Reset has priority over `tx_start` in the same cycle.

## Timing
- Acceptance edge N (IDLE, `tx_start`=1):
  - From edge N: `tx`=0, `tx_busy`=1, and `par_load`=1 for exactly one cycle.
- Start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- Frame length F = (1 + WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- `tx_done`=1 during the F-th cycle after acceptance.
- `tx_busy` falls the cycle after `tx_done`; the earliest next acceptance is that cycle.
- Back-to-back throughput is one frame per F+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `par_bit` is sampled on PARITY entry, at least (1+WIDTH)×CLKS_PER_BIT cycles after `par_load`.

## Structure
- Shared package `uart_pkg`:
  - State enum encoding.
  - Parameter-legality constants (minimum CLKS_PER_BIT, allowed STOP_BITS).
  - Helper function for the baud-counter width.
- Sub-module `uart_baud_cnt`:
  - Loadable down-counter with an `end_of_bit` flag.
  - Reused later by the receiver at 16× oversampling.
- The parity generator is instantiated at the transmitter top level, not inside this block.

## Test plan
- Even parity, defaults, `tx_data`=8'hE9:
  - `tx` bit sequence is 0,1,0,0,1,0,1,1,1,(parity)1,(stop)1, each 16 cycles.
  - `tx_done` arrives 176 cycles after acceptance.
  - `par_load` pulses exactly once.
- PARITY_ODD=1 with 8'hE9: parity bit is 0. PARITY_EN=0: frame is 10 bit periods (160 cycles) with no parity slot.
- STOP_BITS=2 with 8'h00:
  - Data bits are all 0; parity bit is 0 (even).
  - `tx` is high for 32 cycles before `tx_done`.
- `tx_start` pulsed mid-frame with 8'h55:
  - Current frame completes unchanged.
  - 8'h55 is never sent; `tx_busy` stays 1 until the frame ends.
- `rst`=0 asserted during DATA bit 3:
  - Next cycle `tx`=1, `tx_busy`=0.
  - No `tx_done` pulse.
  - A subsequent `tx_start` sends a clean full frame.
- `tx_start` held high for 3 frames:
  - Frames are separated by exactly one IDLE cycle.
  - Each frame carries the `tx_data` value present at its acceptance edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parameter-legality limits
// and the counter-width helper used by the transmit and receive datapaths.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    // Bits needed to hold CLKS_PER_BIT-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int clks_per_bit);
        if (clks_per_bit <= CLKS_PER_BIT_MIN) begin
            return 1;
        end else begin
            return $clog2(clks_per_bit);
        end
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; end_of_bit marks the last cycle of a period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = baud_cnt_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    output logic [CW-1:0] cnt,
    output logic          end_of_bit
);

    logic [CW-1:0] cnt_r;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= CW'(CLKS_PER_BIT - 1);
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt        = cnt_r;
    assign end_of_bit = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start/busy handshake, parity-generator
// sequencing and serialisation of start, data, parity and stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx,
    output logic             par_load,
    output logic [WIDTH-1:0] par_data,
    input  logic             par_bit
);

    localparam int   CW      = baud_cnt_width(CLKS_PER_BIT);
    localparam int   BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int   NSTOP   = (STOP_BITS >= STOP_BITS_MAX) ? STOP_BITS_MAX : STOP_BITS_MIN;
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    tx_state_e        state_r, state_nx;
    logic [WIDTH-1:0] shift_r, shift_nx;
    logic [WIDTH-1:0] par_data_r, par_data_nx;
    logic [BW-1:0]    bit_r, bit_nx;
    logic             tx_r, tx_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
    logic             par_load_r, par_load_nx;
    logic             baud_load_s;
    logic             end_of_bit_s;
    logic [CW-1:0]    baud_cnt_s;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (baud_load_s),
        .cnt       (baud_cnt_s),
        .end_of_bit(end_of_bit_s)
    );

    // Next-state and next-output logic; outputs are computed one cycle ahead so they leave registered.
    always_comb begin
        state_nx    = state_r;
        shift_nx    = shift_r;
        par_data_nx = par_data_r;
        bit_nx      = bit_r;
        tx_nx       = tx_r;
        busy_nx     = busy_r;
        done_nx     = 1'b0;
        par_load_nx = 1'b0;
        baud_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_nx   = 1'b1;
                busy_nx = 1'b0;
                if (tx_start) begin
                    state_nx    = ST_START;
                    shift_nx    = tx_data;
                    par_data_nx = tx_data;
                    par_load_nx = 1'b1;
                    bit_nx      = {BW{1'b0}};
                    tx_nx       = 1'b0;
                    busy_nx     = 1'b1;
                    baud_load_s = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (end_of_bit_s) begin
                    state_nx    = ST_DATA;
                    tx_nx       = shift_r[0];
                    baud_load_s = 1'b1;
                end else begin
                    state_nx = ST_START;
                end
            end
            ST_DATA: begin
                if (end_of_bit_s) begin
                    baud_load_s = 1'b1;
                    shift_nx    = shift_r >> 1'b1;
                    if (bit_r == BW'(WIDTH - 1)) begin
                        bit_nx = {BW{1'b0}};
                        // par_bit has been settled since shortly after the start bit began.
                        if (PARITY_EN != 0) begin
                            state_nx = ST_PARITY;
                            tx_nx    = par_bit ^ PAR_ODD;
                        end else begin
                            state_nx = ST_STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_r + BW'(1);
                        tx_nx  = shift_nx[0];
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (end_of_bit_s) begin
                    state_nx    = ST_STOP;
                    tx_nx       = 1'b1;
                    bit_nx      = {BW{1'b0}};
                    baud_load_s = 1'b1;
                end else begin
                    state_nx = ST_PARITY;
                end
            end
            ST_STOP: begin
                tx_nx = 1'b1;
                // Count 1 is the penultimate cycle, so done lands on the final one.
                if ((bit_r == BW'(NSTOP - 1)) && (baud_cnt_s == CW'(1))) begin
                    done_nx = 1'b1;
                end else begin
                    done_nx = 1'b0;
                end
                if (end_of_bit_s) begin
                    if (bit_r == BW'(NSTOP - 1)) begin
                        state_nx = ST_IDLE;
                        busy_nx  = 1'b0;
                        bit_nx   = {BW{1'b0}};
                    end else begin
                        bit_nx      = bit_r + BW'(1);
                        baud_load_s = 1'b1;
                    end
                end else begin
                    state_nx = ST_STOP;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
                bit_nx   = {BW{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {WIDTH{1'b0}};
            par_data_r <= {WIDTH{1'b0}};
            bit_r      <= {BW{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            par_load_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            shift_r    <= shift_nx;
            par_data_r <= par_data_nx;
            bit_r      <= bit_nx;
            tx_r       <= tx_nx;
            busy_r     <= busy_nx;
            done_r     <= done_nx;
            par_load_r <= par_load_nx;
        end
    end

    assign tx       = tx_r;
    assign tx_busy  = busy_r;
    assign tx_done  = done_r;
    assign par_load = par_load_r;
    assign par_data = par_data_r;

endmodule
